video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 170 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, sync, display enable and
// line/frame strobes, with per-frame sync adjustment and optional interlaced fields.
module video_timing_gen #(
  parameter int W            = 9,
  parameter int H_TOTAL      = 443,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 275,
  parameter int H_SYNC_END   = 300,
  parameter int V_TOTAL      = 263,
  parameter int V_ACT_START  = 17,
  parameter int V_ACT_END    = 240,
  parameter int V_SYNC_START = 243,
  parameter int V_SYNC_END   = 246,
  parameter int SYNC_POL     = 0,
  parameter int INTERLACE    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [3:0]   h_adj,
  input  logic [3:0]   v_adj,
  output logic [W-1:0] hcount,
  output logic [W-1:0] vcount,
  output logic         hb,
  output logic         vb,
  output logic         de,
  output logic         hs,
  output logic         vs,
  output logic         field,
  output logic         line,
  output logic         frame
);

  localparam logic [W-1:0] HLAST     = W'(H_TOTAL - 1);
  localparam logic [W-1:0] HHALF     = W'(H_TOTAL / 2);
  localparam logic [W-1:0] HACT      = W'(H_ACTIVE);
  localparam logic [W-1:0] VLAST     = W'(V_TOTAL - 1);
  localparam logic [W-1:0] VLAST_ODD = W'(V_TOTAL);
  localparam logic [W-1:0] VA_START  = W'(V_ACT_START);
  localparam logic [W-1:0] VA_END    = W'(V_ACT_END);

  localparam logic signed [W+1:0] HSS  = (W+2)'(H_SYNC_START);
  localparam logic signed [W+1:0] HSE  = (W+2)'(H_SYNC_END);
  localparam logic signed [W+1:0] HMAX = (W+2)'(H_TOTAL - 1);
  localparam logic signed [W+1:0] VSS  = (W+2)'(V_SYNC_START);
  localparam logic signed [W+1:0] VSE  = (W+2)'(V_SYNC_END);
  localparam logic signed [W+1:0] VMAX = (W+2)'(V_TOTAL - 1);

  localparam logic POL = (SYNC_POL != 0);
  localparam logic IL  = (INTERLACE != 0);

  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL)) begin : g_bad_h
    $error("video_timing_gen: need H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL");
  end
  if (!(V_ACT_START < V_ACT_END && V_ACT_END <= V_SYNC_START &&
        V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_v
    $error("video_timing_gen: need V_ACT_START < V_ACT_END <= V_SYNC_START < V_SYNC_END <= V_TOTAL");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state;
  logic        [3:0] hadj_l, vadj_l;
  logic        [3:0] hadj_n, vadj_n;
  logic [W-1:0]      hc_n, vc_n;
  logic              fld_n, wrap_h, wrap_v;
  logic [W-1:0]      hs_s, hs_e, vs_s, vs_e;
  logic              hb_n, vb_n, hs_act, vs_act, odd;

  function automatic logic signed [W+1:0] sext4(input logic [3:0] a);
    return {{(W-2){a[3]}}, a};
  endfunction

  function automatic logic [W-1:0] clamp(input logic signed [W+1:0] x,
                                         input logic signed [W+1:0] hi);
    logic [W-1:0] r;
    if (x[W+1])      r = '0;
    else if (x > hi) r = hi[W-1:0];
    else             r = x[W-1:0];
    return r;
  endfunction

  // The first ce after reset parks the raster at (0,0) without advancing, so a full
  // frame elapses before the first frame strobe; adjustments are captured there too.
  always_comb begin
    hc_n   = hcount;
    vc_n   = vcount;
    fld_n  = field;
    wrap_h = 1'b0;
    wrap_v = 1'b0;
    hadj_n = hadj_l;
    vadj_n = vadj_l;
    if (state == ST_IDLE) begin
      hc_n = '0;
      vc_n = '0;
    end else if (hcount == HLAST) begin
      hc_n   = '0;
      wrap_h = 1'b1;
      if (vcount == ((IL && field) ? VLAST_ODD : VLAST)) begin
        vc_n   = '0;
        wrap_v = 1'b1;
        if (IL) fld_n = ~field;
      end else begin
        vc_n = vcount + 1'b1;
      end
    end else begin
      hc_n = hcount + 1'b1;
    end
    if (state == ST_IDLE || wrap_v) begin
      hadj_n = h_adj;
      vadj_n = v_adj;
    end
  end

  // Output decode runs on the next-state counters so registered outputs line up
  // with the counter values they are presented alongside.
  always_comb begin
    hs_s   = clamp(HSS + sext4(hadj_n), HMAX);
    hs_e   = clamp(HSE + sext4(hadj_n), HMAX);
    vs_s   = clamp(VSS + sext4(vadj_n), VMAX);
    vs_e   = clamp(VSE + sext4(vadj_n), VMAX);
    odd    = IL && fld_n;
    hb_n   = (hc_n >= HACT);
    vb_n   = (vc_n < VA_START) || (vc_n >= VA_END);
    hs_act = (hc_n >= hs_s) && (hc_n < hs_e);
    if (odd) begin
      vs_act = ((vc_n > vs_s) || (vc_n == vs_s && hc_n >= HHALF)) &&
               ((vc_n < vs_e) || (vc_n == vs_e && hc_n < HHALF));
    end else begin
      vs_act = (vc_n >= vs_s) && (vc_n < vs_e);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      hcount <= '0;
      vcount <= '0;
      field  <= 1'b0;
      hadj_l <= '0;
      vadj_l <= '0;
      hb     <= 1'b0;
      vb     <= 1'b1;
      de     <= 1'b0;
      hs     <= ~POL;
      vs     <= ~POL;
      line   <= 1'b0;
      frame  <= 1'b0;
    end else begin
      line  <= 1'b0;
      frame <= 1'b0;
      if (ce) begin
        state  <= ST_RUN;
        hcount <= hc_n;
        vcount <= vc_n;
        field  <= fld_n;
        hadj_l <= hadj_n;
        vadj_l <= vadj_n;
        hb     <= hb_n;
        vb     <= vb_n;
        de     <= ~hb_n & ~vb_n;
        hs     <= hs_act ? POL : ~POL;
        vs     <= vs_act ? POL : ~POL;
        line   <= wrap_h;
        frame  <= wrap_v;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-geometry vector table, small-geometry random run
// against a linear-position reference model, plus sync clamp, interlace and reset sequences.
module tb_video_timing_gen;

  localparam int SH = 40, SHA = 24, SHSS = 28, SV = 20, SVAS = 2, SVAE = 15, SVSS = 16, SVSE = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [3:0] h_adj = '0;
  logic [3:0] v_adj = '0;

  logic [2:0][8:0] hc, vc;
  logic [2:0]      hb, vb, de, hs, vs, fld, ln, fr;

  always #5 clk = ~clk;

  video_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .h_adj(h_adj), .v_adj(v_adj),
    .hcount(hc[0]), .vcount(vc[0]), .hb(hb[0]), .vb(vb[0]), .de(de[0]), .hs(hs[0]),
    .vs(vs[0]), .field(fld[0]), .line(ln[0]), .frame(fr[0]));

  video_timing_gen #(
    .W(9), .H_TOTAL(SH), .H_ACTIVE(SHA), .H_SYNC_START(SHSS), .H_SYNC_END(SH),
    .V_TOTAL(SV), .V_ACT_START(SVAS), .V_ACT_END(SVAE), .V_SYNC_START(SVSS),
    .V_SYNC_END(SVSE), .SYNC_POL(0), .INTERLACE(0)
  ) u_clamp (
    .clk(clk), .rst_n(rst_n), .ce(ce), .h_adj(h_adj), .v_adj(v_adj),
    .hcount(hc[1]), .vcount(vc[1]), .hb(hb[1]), .vb(vb[1]), .de(de[1]), .hs(hs[1]),
    .vs(vs[1]), .field(fld[1]), .line(ln[1]), .frame(fr[1]));

  video_timing_gen #(
    .W(9), .H_TOTAL(SH), .H_ACTIVE(SHA), .H_SYNC_START(SHSS), .H_SYNC_END(32),
    .V_TOTAL(SV), .V_ACT_START(SVAS), .V_ACT_END(SVAE), .V_SYNC_START(SVSS),
    .V_SYNC_END(SVSE), .SYNC_POL(1), .INTERLACE(1)
  ) u_il (
    .clk(clk), .rst_n(rst_n), .ce(ce), .h_adj(h_adj), .v_adj(v_adj),
    .hcount(hc[2]), .vcount(vc[2]), .hb(hb[2]), .vb(vb[2]), .de(de[2]), .hs(hs[2]),
    .vs(vs[2]), .field(fld[2]), .line(ln[2]), .frame(fr[2]));

  typedef struct {
    int H, HA, HSS, HSE, V, VAS, VAE, VSS, VSE, POL, IL;
  } geom_t;

  typedef struct {
    int n; int h; int v; bit hb; bit vb; bit hs; bit ln;
  } vec_t;

  geom_t g[3];
  vec_t  tbl[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: raster position as a linear pixel index within the current field.
  int pos[3], madjh[3], madjv[3];
  bit run[3], mfld[3], mline[3], mframe[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%h expected 0x%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int d);
    run[d] = 0; pos[d] = 0; mfld[d] = 0; madjh[d] = 0; madjv[d] = 0;
    mline[d] = 0; mframe[d] = 0;
  endtask

  task automatic model_step(input int d);
    int flen;
    if (!rst_n) begin
      model_reset(d);
    end else if (!ce) begin
      mline[d] = 0; mframe[d] = 0;
    end else if (!run[d]) begin
      run[d] = 1; pos[d] = 0; mline[d] = 0; mframe[d] = 0;
      madjh[d] = int'($signed(h_adj)); madjv[d] = int'($signed(v_adj));
    end else begin
      flen = g[d].H * (g[d].V + ((g[d].IL != 0 && mfld[d]) ? 1 : 0));
      pos[d]++;
      mframe[d] = 0;
      if (pos[d] == flen) begin
        pos[d] = 0;
        mframe[d] = 1;
        if (g[d].IL != 0) mfld[d] = !mfld[d];
        madjh[d] = int'($signed(h_adj)); madjv[d] = int'($signed(v_adj));
      end
      mline[d] = (pos[d] % g[d].H == 0);
    end
  endtask

  function automatic int clampi(input int x, input int hi);
    return (x < 0) ? 0 : ((x > hi) ? hi : x);
  endfunction

  function automatic logic [31:0] obs(input int d);
    return {6'b0, hc[d], vc[d], hb[d], vb[d], de[d], hs[d], vs[d], fld[d], ln[d], fr[d]};
  endfunction

  function automatic logic [31:0] exp_obs(input int d);
    int H, h, v, h0, h1, v0, v1, off;
    bit hbx, vbx, hact, vact, pol;
    H    = g[d].H;
    h    = pos[d] % H;
    v    = pos[d] / H;
    h0   = clampi(g[d].HSS + madjh[d], H - 1);
    h1   = clampi(g[d].HSE + madjh[d], H - 1);
    v0   = clampi(g[d].VSS + madjv[d], g[d].V - 1);
    v1   = clampi(g[d].VSE + madjv[d], g[d].V - 1);
    off  = (g[d].IL != 0 && mfld[d]) ? H / 2 : 0;
    pol  = (g[d].POL != 0);
    hbx  = (h >= g[d].HA);
    vbx  = (v < g[d].VAS) || (v >= g[d].VAE);
    hact = (h >= h0) && (h < h1);
    vact = (pos[d] >= v0 * H + off) && (pos[d] < v1 * H + off);
    return {6'b0, 9'(h), 9'(v), hbx, vbx, !hbx && !vbx,
            hact ? pol : !pol, vact ? pol : !pol, mfld[d], mline[d], mframe[d]};
  endfunction

  task automatic check_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      bit inact;
      inact = (g[d].POL == 0);
      chk($sformatf("%s_dut%0d", tag, d), obs(d),
          {6'b0, 9'd0, 9'd0, 1'b0, 1'b1, 1'b0, inact, inact, 1'b0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 3; d++) model_step(d);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en)
        for (int d = 0; d < 3; d++) chk($sformatf("model_dut%0d", d), obs(d), exp_obs(d));
    end
  end

  initial begin
    int cur, cnt;
    bit found;

    g[0] = '{443, 256, 275, 300, 263, 17, 240, 243, 246, 0, 0};
    g[1] = '{SH, SHA, SHSS, SH, SV, SVAS, SVAE, SVSS, SVSE, 0, 0};
    g[2] = '{SH, SHA, SHSS, 32, SV, SVAS, SVAE, SVSS, SVSE, 1, 1};
    for (int d = 0; d < 3; d++) model_reset(d);

    // n = pixels advanced since restart on the default-geometry instance
    tbl.push_back('{0,    0,   0,  0, 1, 1, 0});
    tbl.push_back('{1,    1,   0,  0, 1, 1, 0});
    tbl.push_back('{255,  255, 0,  0, 1, 1, 0});
    tbl.push_back('{256,  256, 0,  1, 1, 1, 0});
    tbl.push_back('{274,  274, 0,  1, 1, 1, 0});
    tbl.push_back('{275,  275, 0,  1, 1, 0, 0});
    tbl.push_back('{299,  299, 0,  1, 1, 0, 0});
    tbl.push_back('{300,  300, 0,  1, 1, 1, 0});
    tbl.push_back('{442,  442, 0,  1, 1, 1, 0});
    tbl.push_back('{443,  0,   1,  0, 1, 1, 1});
    tbl.push_back('{444,  1,   1,  0, 1, 1, 0});
    tbl.push_back('{7093, 5,   16, 0, 1, 1, 0});
    tbl.push_back('{7531, 0,   17, 0, 0, 1, 1});
    tbl.push_back('{7787, 256, 17, 1, 0, 1, 0});

    repeat (3) @(negedge clk);
    check_reset("reset_init");
    chk_en = 1'b1;

    rst_n = 1'b1;
    ce    = 1'b1;
    @(negedge clk);
    cur = 0;
    foreach (tbl[i]) begin
      repeat (tbl[i].n - cur) @(negedge clk);
      cur = tbl[i].n;
      chk($sformatf("tbl%0d_hcount", i), 32'(hc[0]), 32'(tbl[i].h));
      chk($sformatf("tbl%0d_vcount", i), 32'(vc[0]), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_hb", i), 32'(hb[0]), 32'(tbl[i].hb));
      chk($sformatf("tbl%0d_vb", i), 32'(vb[0]), 32'(tbl[i].vb));
      chk($sformatf("tbl%0d_de", i), 32'(de[0]), 32'(!tbl[i].hb && !tbl[i].vb));
      chk($sformatf("tbl%0d_hs", i), 32'(hs[0]), 32'(tbl[i].hs));
      chk($sformatf("tbl%0d_line", i), 32'(ln[0]), 32'(tbl[i].ln));
    end

    // Random pixel enables with sync adjustments changed at arbitrary raster points.
    for (int i = 0; i < 12000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) h_adj = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) v_adj = 4'($urandom_range(0, 15));
      @(negedge clk);
    end

    // One-in-four pixel enable with a fixed negative horizontal offset.
    h_adj = 4'hD;
    v_adj = 4'h0;
    for (int i = 0; i < 4000; i++) begin
      ce = (i % 4 == 0);
      @(negedge clk);
    end

    // Interlaced odd field: vsync asserts half a line into the sync start line.
    ce = 1'b1;
    h_adj = 4'h0;
    cnt = 0;
    for (int i = 0; i < 3000 && cnt < 2; i++) begin
      @(negedge clk);
      if (fr[2]) cnt++;
    end
    chk("il_two_fields_seen", 32'(cnt), 32'd2);
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = (fld[2] && vc[2] == 9'(SVSS) && hc[2] == 9'(SH / 2 - 1));
    end
    chk("il_odd_vs_line_found", 32'(found), 32'd1);
    chk("il_odd_vs_before_half", 32'(vs[2]), 32'd0);
    @(negedge clk);
    chk("il_odd_vs_at_half", 32'(vs[2]), 32'd1);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = (fld[2] && vc[2] == 9'(SV));
    end
    chk("il_odd_extra_line", 32'(found), 32'd1);

    // Sync end at H_TOTAL with +7 offset clamps to the last pixel.
    h_adj = 4'h7;
    cnt = 0;
    for (int i = 0; i < 1000 && cnt < 1; i++) begin
      @(negedge clk);
      if (fr[1]) cnt++;
    end
    chk("clamp_frame_seen", 32'(cnt), 32'd1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      found = (hc[1] == 9'(SH - 2));
    end
    chk("clamp_hs_active_pre_end", 32'({found, hs[1]}), 32'b10);
    @(negedge clk);
    chk("clamp_hs_idle_last_px", 32'(hs[1]), 32'd1);
    @(negedge clk);
    chk("clamp_hs_idle_wrap", 32'({hc[1], hs[1]}), 32'b1);

    // Asynchronous reset in mid-line, then restart and full-frame wait.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = (hc[1] == 9'd30 && vc[1] == 9'd10);
    end
    chk("rst_point_found", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      cnt++;
      found = fr[1];
    end
    chk("restart_first_frame", 32'(cnt), 32'(SH * SV + 1));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
